// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: owner encoding,
// in-flight tag layout and the RAM window helper.
package ram_arbiter_pkg;

  // Owner encoding carried in every in-flight tag.
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // In-flight tag layout: {err, iswrite, owner, valid}.
  localparam int TAG_VALID   = 0;
  localparam int TAG_OWNER   = 1;
  localparam int TAG_ISWRITE = 2;
  localparam int TAG_ERR     = 3;
  localparam int TAG_W       = 4;

  // First byte address past the RAM window (4 bytes per word).
  function automatic logic [32:0] ram_limit(input int lgszw);
    return 33'd4 << lgszw;
  endfunction

endpackage

// File: rtl/ram_arbiter_tagpipe.sv
// Fixed-depth shift register carrying one tag per accepted request until
// the matching RAM response (or local error reply) is due.
module ram_arbiter_tagpipe
  import ram_arbiter_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] push_tag,
  output logic [TAG_W-1:0] head_tag
);

  logic [TAG_W-1:0] stage [LATENCY];

  // Shift every cycle; reset invalidates every in-flight tag.
  always_ff @(posedge clk) begin
    // NOTE: this small array is reset on purpose -- a stale valid bit would
    // surface as a phantom response. Non-blocking updates let every stage
    // read its neighbour's old value, which is what makes it a shift register.
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign head_tag = stage[LATENCY-1];

endmodule

// File: rtl/ram_arbiter.sv
// Shares one block RAM between m0 (processor) and m1 (debug/loader):
// round-robin grant with an m1 lock, pass-through request path, tag
// pipeline matching the RAM read latency (1..4) and registered responses.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int LGSZW   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_rq_valid,
  output logic             m0_rq_ready,
  input  logic [31:0]      m0_rq_addr,
  input  logic             m0_rq_iswrite,
  input  logic [31:0]      m0_rq_data,
  output logic             m0_rs_valid,
  output logic [31:0]      m0_rs_data,
  output logic             m0_rs_err,
  input  logic             m1_rq_valid,
  output logic             m1_rq_ready,
  input  logic [31:0]      m1_rq_addr,
  input  logic             m1_rq_iswrite,
  input  logic [31:0]      m1_rq_data,
  input  logic             m1_rq_lock,
  output logic             m1_rs_valid,
  output logic [31:0]      m1_rs_data,
  output logic             m1_rs_err,
  output logic             ram_rq_en,
  output logic [LGSZW+1:0] ram_addr,
  output logic             ram_write_enable,
  output logic [31:0]      ram_write,
  input  logic             ram_rs_en,
  input  logic [31:0]      ram_read
);

  logic             last_grant;
  logic             lock_q;
  logic             grant_m0;
  logic             grant_m1;
  logic             accept;
  logic             sel_owner;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_data;
  logic             sel_iswrite;
  logic             in_window;
  logic [TAG_W-1:0] push_tag;
  logic [TAG_W-1:0] head_tag;
  logic             head_read;

  // Grant: active m1 lock first, then round-robin on contention, else the lone requester.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (!reset) begin
      if (lock_q && m1_rq_valid && m1_rq_lock) begin
        grant_m1 = 1'b1;
      end else if (m0_rq_valid && m1_rq_valid) begin
        if (last_grant == OWNER_M1) grant_m0 = 1'b1;
        else                        grant_m1 = 1'b1;
      end else begin
        grant_m0 = m0_rq_valid;
        grant_m1 = m1_rq_valid;
      end
    end
  end

  assign m0_rq_ready = grant_m0;
  assign m1_rq_ready = grant_m1;

  // Request path: steer the winner straight to the RAM and build its tag.
  always_comb begin
    accept           = grant_m0 | grant_m1;
    sel_owner        = grant_m1 ? OWNER_M1 : OWNER_M0;
    sel_addr         = grant_m1 ? m1_rq_addr : m0_rq_addr;
    sel_data         = grant_m1 ? m1_rq_data : m0_rq_data;
    sel_iswrite      = grant_m1 ? m1_rq_iswrite : m0_rq_iswrite;
    in_window        = {1'b0, sel_addr} < ram_limit(LGSZW);
    ram_rq_en        = accept && in_window;
    ram_addr         = sel_addr[LGSZW+1:0];
    ram_write_enable = ram_rq_en && sel_iswrite;
    ram_write        = sel_data;
    push_tag         = '0;
    if (accept) begin
      push_tag[TAG_VALID]   = 1'b1;
      push_tag[TAG_OWNER]   = sel_owner;
      push_tag[TAG_ISWRITE] = sel_iswrite;
      push_tag[TAG_ERR]     = !in_window;
    end
  end

  // Round-robin pointer and lock state move only on an accepted grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWNER_M1;
      lock_q     <= 1'b0;
    end else if (accept) begin
      last_grant <= sel_owner;
      lock_q     <= grant_m1 && m1_rq_lock;
    end else begin
      lock_q     <= 1'b0;
    end
  end

  ram_arbiter_tagpipe #(.LATENCY(LATENCY)) u_tagpipe (
    .clk      (clk),
    .reset    (reset),
    .push_tag (push_tag),
    .head_tag (head_tag)
  );

  assign head_read = head_tag[TAG_VALID] && !head_tag[TAG_ISWRITE] && !head_tag[TAG_ERR];

  // Register the response for the owner of the head tag; data only for in-window reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rs_valid <= 1'b0;
      m0_rs_data  <= '0;
      m0_rs_err   <= 1'b0;
      m1_rs_valid <= 1'b0;
      m1_rs_data  <= '0;
      m1_rs_err   <= 1'b0;
    end else begin
      m0_rs_valid <= head_tag[TAG_VALID] && (head_tag[TAG_OWNER] == OWNER_M0);
      m0_rs_err   <= head_tag[TAG_VALID] && (head_tag[TAG_OWNER] == OWNER_M0) && head_tag[TAG_ERR];
      m0_rs_data  <= (head_read && (head_tag[TAG_OWNER] == OWNER_M0)) ? ram_read : '0;
      m1_rs_valid <= head_tag[TAG_VALID] && (head_tag[TAG_OWNER] == OWNER_M1);
      m1_rs_err   <= head_tag[TAG_VALID] && (head_tag[TAG_OWNER] == OWNER_M1) && head_tag[TAG_ERR];
      m1_rs_data  <= (head_read && (head_tag[TAG_OWNER] == OWNER_M1)) ? ram_read : '0;
    end
  end

  // An in-window head tag must coincide with the RAM response strobe.
  a_rs_missing: assert property (@(posedge clk) disable iff (reset)
    (head_tag[TAG_VALID] && !head_tag[TAG_ERR]) |-> ram_rs_en);

  // A RAM response strobe with no in-window head tag is unexpected.
  a_rs_stray: assert property (@(posedge clk) disable iff (reset)
    ram_rs_en |-> (head_tag[TAG_VALID] && !head_tag[TAG_ERR]));

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM with fixed latency,
// reference memory and an expected-response queue checked in order.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int LGSZW = 8;
  localparam int LAT   = 3;
  localparam int WORDS = 1 << LGSZW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             m0_rq_valid, m0_rq_ready, m0_rq_iswrite;
  logic [31:0]      m0_rq_addr, m0_rq_data;
  logic             m0_rs_valid, m0_rs_err;
  logic [31:0]      m0_rs_data;
  logic             m1_rq_valid, m1_rq_ready, m1_rq_iswrite, m1_rq_lock;
  logic [31:0]      m1_rq_addr, m1_rq_data;
  logic             m1_rs_valid, m1_rs_err;
  logic [31:0]      m1_rs_data;
  logic             ram_rq_en, ram_write_enable, ram_rs_en;
  logic [LGSZW+1:0] ram_addr;
  logic [31:0]      ram_write, ram_read;

  ram_arbiter #(.LGSZW(LGSZW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_rq_valid(m0_rq_valid), .m0_rq_ready(m0_rq_ready), .m0_rq_addr(m0_rq_addr),
    .m0_rq_iswrite(m0_rq_iswrite), .m0_rq_data(m0_rq_data),
    .m0_rs_valid(m0_rs_valid), .m0_rs_data(m0_rs_data), .m0_rs_err(m0_rs_err),
    .m1_rq_valid(m1_rq_valid), .m1_rq_ready(m1_rq_ready), .m1_rq_addr(m1_rq_addr),
    .m1_rq_iswrite(m1_rq_iswrite), .m1_rq_data(m1_rq_data), .m1_rq_lock(m1_rq_lock),
    .m1_rs_valid(m1_rs_valid), .m1_rs_data(m1_rs_data), .m1_rs_err(m1_rs_err),
    .ram_rq_en(ram_rq_en), .ram_addr(ram_addr), .ram_write_enable(ram_write_enable),
    .ram_write(ram_write), .ram_rs_en(ram_rs_en), .ram_read(ram_read)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural RAM: fixed latency, answers every strobe.
  logic [31:0] ram_mem [WORDS];
  logic        pipe_en [LAT];
  logic [31:0] pipe_data [LAT];

  initial for (int i = 0; i < LAT; i++) begin
    pipe_en[i] = 1'b0;
    pipe_data[i] = '0;
  end

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_en[i]   <= pipe_en[i-1];
      pipe_data[i] <= pipe_data[i-1];
    end
    pipe_en[0]   <= ram_rq_en;
    pipe_data[0] <= ram_mem[ram_addr[LGSZW+1:2]];
    if (ram_rq_en && ram_write_enable) ram_mem[ram_addr[LGSZW+1:2]] <= ram_write;
  end

  assign ram_rs_en = pipe_en[LAT-1];
  assign ram_read  = pipe_data[LAT-1];

  // Scoreboard state.
  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [WORDS];
  logic        grant_log[$];
  int          rs_cycles[$];
  int          rq_en_count = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic note_accept(input logic owner, input logic [31:0] addr,
                             input logic wr, input logic [31:0] data);
    exp_t e;
    e.owner = owner;
    e.cyc   = cyc;
    e.err   = 1'b0;
    e.data  = '0;
    if ((addr >> (LGSZW + 2)) != 0) e.err = 1'b1;
    else if (wr) ref_mem[addr[LGSZW+1:2]] = data;
    else e.data = ref_mem[addr[LGSZW+1:2]];
    sb.push_back(e);
    grant_log.push_back(owner);
  endtask

  // Monitor: responses are compared first, then this cycle's accepts are queued.
  initial forever begin
    @(negedge clk);
    if (ram_rq_en) rq_en_count++;
    if (m0_rs_valid || m1_rs_valid) begin
      rs_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_rs", {30'd0, m1_rs_valid, m0_rs_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rs_both_valid", {31'd0, m0_rs_valid & m1_rs_valid}, 32'd0);
        check("rs_owner", {31'd0, m1_rs_valid}, {31'd0, e.owner});
        check("rs_data", m1_rs_valid ? m1_rs_data : m0_rs_data, e.data);
        check("rs_err", {31'd0, m1_rs_valid ? m1_rs_err : m0_rs_err}, {31'd0, e.err});
        check("rs_latency", cyc - e.cyc, LAT + 1);
      end
    end
    if (m0_rq_valid && m0_rq_ready) note_accept(OWNER_M0, m0_rq_addr, m0_rq_iswrite, m0_rq_data);
    if (m1_rq_valid && m1_rq_ready) note_accept(OWNER_M1, m1_rq_addr, m1_rq_iswrite, m1_rq_data);
  end

  task automatic set_req(input int m, input logic v, input logic [31:0] a,
                         input logic w, input logic [31:0] d, input logic lk);
    if (m == 0) begin
      m0_rq_valid = v; m0_rq_addr = a; m0_rq_iswrite = w; m0_rq_data = d;
    end else begin
      m1_rq_valid = v; m1_rq_addr = a; m1_rq_iswrite = w; m1_rq_data = d; m1_rq_lock = lk;
    end
  endtask

  // Present one request, hold it until accepted (bounded), then withdraw it.
  task automatic do_req(input int m, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic lk);
    int   n = 0;
    logic rdy;
    set_req(m, 1'b1, a, w, d, lk);
    do begin
      @(negedge clk);
      n++;
      rdy = (m == 0) ? m0_rq_ready : m1_rq_ready;
    end while (!rdy && n < 50);
    if (!rdy) check("accept_timeout", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    #1;
    set_req(m, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    sb.delete();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  logic exp_lock [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic exp_alt  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    set_req(0, 1'b0, '0, 1'b0, '0, 1'b0);
    set_req(1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < WORDS; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state: nothing ready, no responses, no RAM strobe.
    m0_rq_valid = 1'b1;
    m1_rq_valid = 1'b1;
    @(negedge clk);
    check("rst_m0_ready", {31'd0, m0_rq_ready}, 32'd0);
    check("rst_m1_ready", {31'd0, m1_rq_ready}, 32'd0);
    check("rst_rs_valid", {30'd0, m1_rs_valid, m0_rs_valid}, 32'd0);
    check("rst_rs_err", {30'd0, m1_rs_err, m0_rs_err}, 32'd0);
    check("rst_m0_rs_data", m0_rs_data, 32'd0);
    check("rst_m1_rs_data", m1_rs_data, 32'd0);
    check("rst_ram_rq_en", {31'd0, ram_rq_en}, 32'd0);
    @(posedge clk);
    #1;
    m0_rq_valid = 1'b0;
    m1_rq_valid = 1'b0;
    do_reset(LAT + 2);

    // m0 write then read back.
    do_req(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_req(0, 32'h10, 1'b0, 32'h0, 1'b0);
    drain();

    // Lock: pointer now favours m1; m1 keeps 4 beats, m0 wins when lock drops.
    grant_log.delete();
    fork
      do_req(0, 32'h14, 1'b0, 32'h0, 1'b0);
      begin
        for (int i = 0; i < 4; i++) do_req(1, 32'h40 + 32'(4 * i), 1'b1, 32'h1000 + 32'(i), 1'b1);
        do_req(1, 32'h50, 1'b1, 32'h2000, 1'b0);
      end
    join
    drain();
    check("lock_grants", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("lock_grant%0d", i), {31'd0, grant_log[i]}, {31'd0, exp_lock[i]});

    // Out of window: error reply, no RAM strobe; then window boundary.
    rq_en_count = 0;
    do_req(0, 32'h1001_200C, 1'b0, 32'h0, 1'b0);
    do_req(1, 32'h400, 1'b1, 32'h55, 1'b0);
    drain();
    check("oow_no_ram_rq", rq_en_count, 0);
    do_req(1, 32'h3FC, 1'b1, 32'h7777_1234, 1'b0);
    do_req(0, 32'h3FC, 1'b0, 32'h0, 1'b0);
    drain();
    check("edge_ram_rq", rq_en_count, 2);

    // Reset the cycle after an m1 read is accepted: its response must vanish.
    rs_cycles.delete();
    do_req(1, 32'h10, 1'b0, 32'h0, 1'b0);
    do_reset(LAT + 2);
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("rst_no_rs", rs_cycles.size(), 0);

    // Contention right after reset: m0 first, then strict alternation.
    grant_log.delete();
    fork
      for (int i = 0; i < 3; i++) do_req(0, 32'h10 + 32'(4 * i), 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) do_req(1, 32'h80 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i), 1'b0);
    join
    drain();
    check("alt_grants", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("alt_grant%0d", i), {31'd0, grant_log[i]}, {31'd0, exp_alt[i]});

    // Back-to-back reads: three consecutive response cycles.
    for (int i = 0; i < 3; i++) do_req(0, 32'(4 * i), 1'b1, 32'hC0DE_0000 + 32'(i), 1'b0);
    drain();
    rs_cycles.delete();
    for (int i = 0; i < 3; i++) do_req(0, 32'(4 * i), 1'b0, 32'h0, 1'b0);
    drain();
    check("b2b_count", rs_cycles.size(), 3);
    if (rs_cycles.size() == 3) begin
      check("b2b_gap0", rs_cycles[1] - rs_cycles[0], 1);
      check("b2b_gap1", rs_cycles[2] - rs_cycles[1], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
